ext_pipe_unit: RTL and testbench

- Parametrised immediate-extension unit for the ID stage.
- Generalises extension to any DATA_W/IMM_W and adds two modes plus an error flag for reserved control codes.
- Registers each result in a DEPTH-entry output queue with valid/ready handshakes on both sides, so ID-side decode decouples from EX-side stalls.
- Supports a synchronous pipeline flush.

---
 rtl/ext_pipe_unit.sv | 72 +++++++
 tb/tb_ext_pipe_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: immediate extension feeding a DEPTH-entry valid/ready output queue with flush.
// Optional EXT_BYPASS_EN enables zero-latency pass-through when the queue is empty.
module ext_pipe_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEPTH  = 2
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IMM_W-1:0]             in_imm,
  input  logic [2:0]                   in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_imm,
  output logic                         out_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] w_s, w_z, w_ext;
  logic              w_err, w_push, w_pop, w_byp, w_nonempty;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_cnt;

  always_comb begin
    w_z   = {{(DATA_W-IMM_W){1'b0}}, in_imm};
    w_s   = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    w_err = in_ctrl[2] & in_ctrl[1];
    w_ext = in_ctrl == 3'd0 ? w_z :
            in_ctrl == 3'd1 ? w_s :
            in_ctrl == 3'd2 ? w_z << IMM_W :
            in_ctrl == 3'd3 ? w_s << 2 :
            in_ctrl == 3'd4 ? {{(DATA_W-IMM_W){1'b1}}, in_imm} :
            in_ctrl == 3'd5 ? w_s << 1 : '0;
  end

`ifdef EXT_BYPASS_EN
  assign w_byp = ~w_nonempty & in_valid & out_ready & ~flush & ~reset;
`else
  assign w_byp = 1'b0;
`endif

  assign w_nonempty = r_cnt != '0;
  assign in_ready   = r_cnt != CW'(DEPTH);
  assign out_valid  = w_nonempty | w_byp;
  // A bypassed item is consumed live, so it never occupies a slot.
  assign w_push     = in_valid & in_ready & ~flush & ~w_byp;
  assign w_pop      = w_nonempty & out_ready & ~flush;
  assign out_imm    = w_byp ? w_ext : w_nonempty ? r_mem[r_rd][DATA_W-1:0] : '0;
  assign out_err    = w_byp ? w_err : w_nonempty & r_mem[r_rd][DATA_W];
  assign count      = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == PW'(DEPTH-1) ? '0 : r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd == PW'(DEPTH-1) ? '0 : r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_err, w_ext};
  end
endmodule

// File: tb/tb_ext_pipe_unit.sv
// tb_ext_pipe_unit: scoreboard bench for ext_pipe_unit (DATA_W=32, IMM_W=16, DEPTH=2).
module tb_ext_pipe_unit;
  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_imm = '0;
  logic [2:0]  in_ctrl = '0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_imm;
  logic [1:0]  count;
  logic [32:0] sb [$];
  int          total = 0, bad = 0;

  ext_pipe_unit #(.DATA_W(32), .IMM_W(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_err(out_err), .count(count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] imm, input logic [2:0] c, input logic [31:0] e_imm, input logic e_err);
    in_valid = 1;
    in_imm   = imm;
    in_ctrl  = c;
    if (in_ready && !flush && !reset) sb.push_back({e_err, e_imm});
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h/%b", out_imm, out_err);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({out_err, out_imm} !== e) begin
          bad++;
          $display("FAIL sb_out got=%b/%h exp=%b/%h", out_err, out_imm, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_err", out_err, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);
    // first push latency
    drive(16'h8000, 3'd1, 32'hFFFF8000, 0);
    tick();
    in_valid = 0;
    chk("lat_valid", out_valid, 1);
    chk("lat_imm", out_imm, 32'hFFFF8000);
    chk("lat_err", out_err, 0);
    chk("lat_count", count, 1);
    out_ready = 1;
    tick();
    chk("lat_drained", count, 0);
    // streaming mode sweep
    drive(16'h8000, 3'd0, 32'h00008000, 0); tick();
    drive(16'hFFFE, 3'd2, 32'hFFFE0000, 0); tick();
    drive(16'hFFFE, 3'd3, 32'hFFFFFFF8, 0); tick();
    drive(16'hFFFE, 3'd4, 32'hFFFFFFFE, 0); tick();
    drive(16'hFFFE, 3'd5, 32'hFFFFFFFC, 0); tick();
    drive(16'hFFFE, 3'd6, 32'h00000000, 1); tick();
    drive(16'h1234, 3'd7, 32'h00000000, 1); tick();
    drive(16'hFFFE, 3'd0, 32'h0000FFFE, 0); tick();
    drive(16'hFFFE, 3'd1, 32'hFFFFFFFE, 0); tick();
    drive(16'h4001, 3'd3, 32'h00010004, 0); tick();
    drive(16'h0003, 3'd4, 32'hFFFF0003, 0); tick();
    in_valid = 0;
    tick(); tick();
    chk("sweep_drained", count, 0);
    // backpressure and hold
    out_ready = 0;
    drive(16'h0001, 3'd0, 32'h1, 0); tick();
    drive(16'h0002, 3'd0, 32'h2, 0); tick();
    chk("full_count", count, 2);
    chk("full_ready", in_ready, 0);
    drive(16'h0003, 3'd0, 32'h3, 0); tick();
    in_valid = 0;
    chk("full_hold_count", count, 2);
    chk("full_hold_imm", out_imm, 32'h1);
    tick();
    chk("full_hold_imm2", out_imm, 32'h1);
    out_ready = 1;
    tick();
    chk("bp_pop1_count", count, 1);
    chk("bp_pop1_head", out_imm, 32'h2);
    tick();
    chk("bp_empty", count, 0);
    chk("bp_empty_valid", out_valid, 0);
    // simultaneous push/pop with pointer wrap
    out_ready = 0;
    drive(16'h00A0, 3'd0, 32'hA0, 0); tick();
    out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      drive(16'h00A0 + 16'(i), 3'd0, 32'hA0 + 32'(i), 0);
      tick();
      chk("pp_count", count, 1);
      chk("pp_head", out_imm, 32'hA0 + 32'(i));
    end
    in_valid = 0;
    tick();
    chk("pp_drained", count, 0);
    // flush while full with a pending input
    out_ready = 0;
    drive(16'h0010, 3'd0, 32'h10, 0); tick();
    drive(16'h0011, 3'd0, 32'h11, 0); tick();
    chk("pre_flush_count", count, 2);
    flush = 1;
    drive(16'h0099, 3'd0, 32'h99, 0);
    tick();
    flush = 0;
    in_valid = 0;
    sb.delete();
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_imm", out_imm, 0);
    out_ready = 1;
    drive(16'h0055, 3'd0, 32'h55, 0); tick();
    in_valid = 0;
    tick();
    // asynchronous reset mid-cycle
    out_ready = 0;
    drive(16'h0077, 3'd1, 32'h77, 0); tick();
    in_valid = 0;
    chk("pre_rst_count", count, 1);
    #2 reset = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_imm", out_imm, 0);
    chk("arst_err", out_err, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    sb.delete();
    tick();
    reset = 0;
    tick();
    // empty queue, producer and consumer both active
    out_ready = 1;
    drive(16'h8001, 3'd1, 32'hFFFF8001, 0);
    #1;
`ifdef EXT_BYPASS_EN
    chk("byp_valid", out_valid, 1);
    chk("byp_imm", out_imm, 32'hFFFF8001);
    chk("byp_count", count, 0);
    tick();
    in_valid = 0;
    chk("byp_count_after", count, 0);
`else
    chk("nobyp_valid", out_valid, 0);
    chk("nobyp_imm", out_imm, 0);
    tick();
    in_valid = 0;
    chk("nobyp_valid_after", out_valid, 1);
    chk("nobyp_imm_after", out_imm, 32'hFFFF8001);
`endif
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 0);
    tick();
    chk("final_count", count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
